keypad_scan: RTL
================

# keypad_scan

Scanner for a 4x4 active-low matrix keypad, the input-side counterpart of the multiplexed seven-segment driver. It drives one column low at a time, senses the row lines and debounces over whole scan frames. Each accepted press is emitted as a one-cycle ASCII keycode event and shifted into a 32-bit, four-character word that connects directly to the display driver's `word` input.

## Interface
- `SCAN_DIV`, 100000: clock cycles each column is driven (1 ms at 100 MHz); ≥ 4.
- `DEBOUNCE_SCANS`, 10: consecutive frames needed to accept a press or a release; 2..255.
- `clk` input 1: system clock, 100 MHz.
- `reset_n` input 1: asynchronous reset, active low. Fixed: one clock; reset is asynchronous and active-low.
- `row` input 4: keypad rows, externally pulled up; low = key closed on the driven column.
- `col` output 4: column drives, active low; exactly one bit low at any time.
- `key_valid` output 1: one-cycle pulse, `key_code` valid.
- `key_code` output 8: ASCII code of the last accepted key; held between events.
- `key_down` output 1: high while the accepted key is considered held.
- `word` output 32: last four accepted keys, newest in `[7:0]`.

## Operation
- Key map, row r / col c, lowercase ASCII:
  - r0: "1" "2" "3" "a"
  - r1: "4" "5" "6" "b"
  - r2: "7" "8" "9" "c"
  - r3: "e" "0" "f" "d"
- `row` passes through a 2-flop synchronizer before use.
- Column slot counter runs 0..SCAN_DIV-1. The column index advances 0→1→2→3→0 when the counter wraps. `col` = ~(1<<index).
- Row sample is taken at counter value SCAN_DIV-1, the last cycle of the slot, to allow settling.
- Frame = 4 slots. The frame result is evaluated at the end of column 3 and is one of:
  - NONE: no closed contact.
  - SINGLE(code): exactly one contact.
  - MULTI: two or more contacts.
- FSM, updated only at frame end:
  - IDLE: SINGLE(k) → PRESS_DB with cand=k, cnt=1. Otherwise stay.
  - PRESS_DB:
    - SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE_SCANS → HELD, pulse `key_valid`, `key_code`=cand, `word`={word[23:0],cand}, `key_down`=1.
    - SINGLE(other): restart with cand=other, cnt=1.
    - NONE or MULTI: → IDLE.
  - HELD: frame where cand's contact is not closed → RELEASE_DB, cnt=1. Otherwise stay; extra keys are ignored.
  - RELEASE_DB:
    - cand closed: → HELD, no new pulse.
    - Else cnt+1. When cnt reaches DEBOUNCE_SCANS → IDLE, `key_down`=0.
- Counters saturate at 8 bits; no wrap.

## Timing
- Reset values: `col`=4'b1110, `key_valid`=0, `key_code`=8'h20, `key_down`=0, `word`=32'h20202020. FSM in IDLE, slot counter 0, column 0.
- `reset_n` low mid-frame aborts the frame and the FSM immediately. The first frame after release starts at column 0.
- `key_valid` asserts in the cycle after the accepting frame-end sample. It lasts exactly 1 cycle.
- `key_code` and `word` update in the same cycle as `key_valid`.
- Press-to-event latency is between (DEBOUNCE_SCANS-1)·4·SCAN_DIV and (DEBOUNCE_SCANS+1)·4·SCAN_DIV cycles, plus 3 cycles (synchronizer and register).
- Release sets `key_down`=0 in the cycle after the DEBOUNCE_SCANS-th open frame.
- Frame period is exactly 4·SCAN_DIV cycles, free-running and independent of FSM state.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined:
  - In HELD, a repeat counter counts frames.
  - After 64 held frames, `key_valid` re-pulses with the same `key_code`, and `word` shifts again.
  - Further repeats follow every 16 frames.
  - Entering RELEASE_DB or IDLE clears the counter. Re-entering HELD from RELEASE_DB keeps it.
- Undefined: exactly one `key_valid` per accepted press; no repeat logic is synthesized.

## Test plan
- SCAN_DIV=4, DEBOUNCE_SCANS=3 (frame = 16 cycles) for all scenarios.
1. Reset, no keys → `col` cycles 1110,1101,1011,0111 with 4 cycles per state; `key_valid` never asserts; `word`=32'h20202020.
2. Hold r1/c2 ("6") for 6 frames → one `key_valid`, `key_code`=8'h36, `word`=32'h20202036, `key_down`=1. Release → `key_down`=0 after 3 open frames.
3. Press "1","2","3","a" in sequence, each held 5 frames with 5 open frames between → four pulses; `word`=32'h31323361 ("123a").
4. Bounce: "5" closed for 2 frames, open 1, closed 1, open → no `key_valid`; FSM returns to IDLE.
5. Hold "5", then add "9" for 2 frames → no second pulse, `key_down` stays 1. Open "5" for 2 frames then close it again → no new pulse.
6. Assert `reset_n` low mid-PRESS_DB while "0" is held, then release → all outputs at reset values. "0" is accepted 3 frames later with `key_code`=8'h30. With `KEYPAD_AUTOREPEAT_EN` and a 100-frame hold → pulses at frames 3, 67 and 83.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with frame debounce, ASCII events and a 4-char word.
// Optional KEYPAD_AUTOREPEAT_EN: repeat events while a key stays held.
module keypad_scan #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic        key_valid,
  output logic [7:0]  key_code,
  output logic        key_down,
  output logic [31:0] word
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SLOT_END = CW'(SCAN_DIV - 1);
  localparam logic [7:0] DB_N = 8'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_DB,
    S_HELD,
    S_RELEASE_DB
  } state_t;

  state_t        state, state_n;
  logic [3:0]    row_s1, row_s2;
  logic [CW-1:0] slot_cnt;
  logic [1:0]    col_idx;
  logic [15:0]   hits, cur;
  logic [3:0]    cand, cand_n;
  logic [7:0]    cnt, cnt_n, cnt_inc;
  logic [1:0]    n_hit;
  logic [3:0]    hit_idx;
  logic          sample, frame_end, single;
  logic          accept, rel_done, emit;
  logic [7:0]    cand_ascii;

  function automatic logic [7:0] key_ascii(input logic [3:0] k);
    logic [7:0] a;
    case (k)
      4'd0:    a = 8'h31;
      4'd1:    a = 8'h32;
      4'd2:    a = 8'h33;
      4'd3:    a = 8'h61;
      4'd4:    a = 8'h34;
      4'd5:    a = 8'h35;
      4'd6:    a = 8'h36;
      4'd7:    a = 8'h62;
      4'd8:    a = 8'h37;
      4'd9:    a = 8'h38;
      4'd10:   a = 8'h39;
      4'd11:   a = 8'h63;
      4'd12:   a = 8'h65;
      4'd13:   a = 8'h30;
      4'd14:   a = 8'h66;
      default: a = 8'h64;
    endcase
    return a;
  endfunction

  assign sample     = (slot_cnt == SLOT_END);
  assign frame_end  = sample && (col_idx == 2'd3);
  assign col        = ~(4'b0001 << col_idx);
  assign single     = (n_hit == 2'd1);
  assign cnt_inc    = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign cand_ascii = key_ascii(cand);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_s1   <= 4'hF;
      row_s2   <= 4'hF;
      slot_cnt <= '0;
      col_idx  <= 2'd0;
      hits     <= '0;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
      if (sample) begin
        slot_cnt <= '0;
        col_idx  <= col_idx + 2'd1;
        hits     <= frame_end ? 16'h0 : cur;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  // Contact map of the frame so far, including the column being sampled now
  always_comb begin
    cur = hits;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2[r]) cur[{2'(r), col_idx}] = 1'b1;
    end
  end

  always_comb begin
    n_hit   = 2'd0;
    hit_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (cur[i]) begin
        if (n_hit != 2'd2) n_hit = n_hit + 2'd1;
        hit_idx = 4'(i);
      end
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  logic [7:0] rep, rep_n, rep_inc;
  logic       repeat_ev;

  assign rep_inc = rep + 8'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rep <= '0;
    else          rep <= rep_n;
  end
`endif

  always_comb begin
    state_n  = state;
    cand_n   = cand;
    cnt_n    = cnt;
    accept   = 1'b0;
    rel_done = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_n     = rep;
    repeat_ev = 1'b0;
`endif
    if (frame_end) begin
      unique case (state)
        S_IDLE: begin
          if (single) begin
            state_n = S_PRESS_DB;
            cand_n  = hit_idx;
            cnt_n   = 8'd1;
          end
        end
        S_PRESS_DB: begin
          if (single && hit_idx == cand) begin
            cnt_n = cnt_inc;
            if (cnt_inc >= DB_N) begin
              state_n = S_HELD;
              accept  = 1'b1;
            end
          end else if (single) begin
            cand_n = hit_idx;
            cnt_n  = 8'd1;
          end else begin
            state_n = S_IDLE;
          end
        end
        S_HELD: begin
          if (!cur[cand]) begin
            state_n = S_RELEASE_DB;
            cnt_n   = 8'd1;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_n = 8'd0;
          end else if (rep_inc == 8'd64) begin
            // Rewind by 16 so later repeats land every 16 frames
            repeat_ev = 1'b1;
            rep_n     = 8'd48;
          end else begin
            rep_n = rep_inc;
`endif
          end
        end
        S_RELEASE_DB: begin
          if (cur[cand]) begin
            state_n = S_HELD;
          end else begin
            cnt_n = cnt_inc;
            if (cnt_inc >= DB_N) begin
              state_n  = S_IDLE;
              rel_done = 1'b1;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  assign emit = accept | repeat_ev;
`else
  assign emit = accept;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cand      <= 4'd0;
      cnt       <= 8'd0;
      key_valid <= 1'b0;
      key_code  <= 8'h20;
      key_down  <= 1'b0;
      word      <= 32'h20202020;
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      key_valid <= emit;
      if (emit) begin
        key_code <= cand_ascii;
        word     <= {word[23:0], cand_ascii};
      end
      if (accept)        key_down <= 1'b1;
      else if (rel_done) key_down <= 1'b0;
    end
  end

endmodule
